// File: rtl/mig_sweep_sched.sv
// Time-multiplexed MAJ3 evaluator: sweeps 128 minterms through a programmable MIG netlist
// and streams the truth table. Optional capture register enabled by defining TT_CAPTURE_EN.
module mig_sweep_sched #(
  parameter int MAX_GATES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [17:0]  cfg_data,
  input  logic         start,
  input  logic [4:0]   num_gates,
  input  logic         out_inv,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         tt_valid,
  input  logic         tt_ready,
  output logic [6:0]   tt_index,
  output logic         tt_bit,
  output logic [127:0] tt_word
);
  localparam int SELW = 5;
  localparam int GW   = $clog2(MAX_GATES);
  localparam logic [SELW-1:0] SEL_END = SELW'(8 + MAX_GATES);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EMIT, S_DONE} st_t;

  st_t                          r_state, w_nxt;
  logic [MAX_GATES-1:0][17:0]   r_tab;
  logic [MAX_GATES-1:0]         r_res;
  logic [4:0]                   r_n;
  logic                         r_oinv;
  logic [6:0]                   r_mt;
  logic [GW-1:0]                r_gate;
  logic                         r_err;

  logic        w_idle, w_legal, w_accept, w_hs, w_last_gate, w_maj, w_out;
  logic [4:0]  w_last;
  logic [17:0] w_ent;

  // Unwritten (forward/self) gate results read 0 because r_res is cleared per minterm.
  function automatic logic f_opnd(input logic [5:0] op, input logic [6:0] x,
                                  input logic [MAX_GATES-1:0] res);
    logic            v;
    logic [SELW-1:0] gi;
    v  = 1'b0;
    gi = op[SELW-1:0] - SELW'(8);
    if (op[SELW-1:0] >= SELW'(1) && op[SELW-1:0] <= SELW'(7))
      v = x[op[2:0] - 3'd1];
    else if (op[SELW-1:0] >= SELW'(8) && op[SELW-1:0] < SEL_END)
      v = res[gi[GW-1:0]];
    return v ^ op[5];
  endfunction

  assign w_idle      = (r_state == S_IDLE);
  assign w_legal     = (num_gates != 5'd0) && (num_gates <= 5'(MAX_GATES));
  assign w_accept    = w_idle && start && w_legal;
  assign w_hs        = (r_state == S_EMIT) && tt_ready;
  assign w_last      = r_n - 5'd1;
  assign w_last_gate = (r_gate == w_last[GW-1:0]);
  assign w_ent       = r_tab[r_gate];
  assign w_out       = r_res[w_last[GW-1:0]] ^ r_oinv;

  always_comb begin
    logic a, b, c;
    a     = f_opnd(w_ent[17:12], r_mt, r_res);
    b     = f_opnd(w_ent[11:6],  r_mt, r_res);
    c     = f_opnd(w_ent[5:0],   r_mt, r_res);
    w_maj = (a & b) | (a & c) | (b & c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nxt = S_EVAL;
      S_EVAL:  if (w_last_gate) w_nxt = S_EMIT;
      S_EMIT:  if (tt_ready) w_nxt = (r_mt == 7'd127) ? S_DONE : S_EVAL;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    tt_valid = (r_state == S_EMIT);
    tt_index = tt_valid ? r_mt : 7'd0;
    tt_bit   = tt_valid & w_out;
    err      = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tab  <= '0;
      r_res  <= '0;
      r_n    <= '0;
      r_oinv <= 1'b0;
      r_mt   <= '0;
      r_gate <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_idle && start && !w_legal;
      if (w_idle && cfg_we) r_tab[cfg_addr] <= cfg_data;
      if (w_accept) begin
        r_n    <= num_gates;
        r_oinv <= out_inv;
        r_mt   <= '0;
        r_gate <= '0;
        r_res  <= '0;
      end
      if (r_state == S_EVAL) begin
        r_res[r_gate] <= w_maj;
        if (!w_last_gate) r_gate <= r_gate + 1'b1;
      end
      if (w_hs && r_mt != 7'd127) begin
        r_mt   <= r_mt + 7'd1;
        r_gate <= '0;
        r_res  <= '0;
      end
    end
  end

`ifdef TT_CAPTURE_EN
  logic [127:0] r_word;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_word <= '0;
    else if (w_accept) r_word <= '0;
    else if (w_hs)     r_word[r_mt] <= w_out;
  end
  assign tt_word = r_word;
`else
  assign tt_word = '0;
`endif

endmodule

// File: tb/tb_mig_sweep_sched.sv
// Randomized self-checking bench for mig_sweep_sched against a per-minterm netlist evaluator.
module tb_mig_sweep_sched;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cfg_we = 1'b0, start = 1'b0, out_inv = 1'b0, tt_ready = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [17:0]  cfg_data = '0;
  logic [4:0]   num_gates = '0;
  logic         busy, done, err, tt_valid, tt_bit;
  logic [6:0]   tt_index;
  logic [127:0] tt_word;

  int n_chk = 0, n_fail = 0;
  logic [17:0]  tab [16];
  logic [127:0] col;

  mig_sweep_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_gates(num_gates), .out_inv(out_inv), .busy(busy), .done(done),
    .err(err), .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_index(tt_index),
    .tt_bit(tt_bit), .tt_word(tt_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit opv(input logic [5:0] op, input int m, input logic [15:0] r);
    int s;
    bit v;
    s = int'(op[4:0]);
    if (s == 0)      v = 1'b0;
    else if (s < 8)  v = ((m >> (s - 1)) & 1) != 0;
    else if (s < 24) v = r[s - 8];
    else             v = 1'b0;
    return v ^ op[5];
  endfunction

  // Evaluate the netlist gate by gate for each minterm; results not yet computed read 0.
  function automatic logic [127:0] model(input int n, input bit oinv);
    logic [127:0] tt;
    logic [15:0]  r;
    bit a, b, c;
    tt = '0;
    for (int m = 0; m < 128; m++) begin
      r = '0;
      for (int g = 0; g < n; g++) begin
        a = opv(tab[g][17:12], m, r);
        b = opv(tab[g][11:6],  m, r);
        c = opv(tab[g][5:0],   m, r);
        r[g] = (a && b) || (a && c) || (b && c);
      end
      tt[m] = r[n-1] ^ oinv;
    end
    return tt;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; tab[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall at idx 10; 3: start/cfg_we while busy
  task automatic sweep(input int n, input bit oinv, input int mode, input bit wr_now,
                       input logic [3:0] wa, input logic [17:0] wd, output logic [127:0] c);
    logic [127:0] exp;
    int cyc, idx, stall;
    bit prev_stall;
    @(negedge clk);
    if (wr_now) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; tab[wa] = wd;
    end
    exp = model(n, oinv);
    start = 1'b1; num_gates = 5'(n); out_inv = oinv;
    tt_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    cyc = 1; idx = 0; stall = 0; prev_stall = 1'b0; c = '0;
    while (!done && cyc < 6000 && idx <= 128) begin
      if (mode == 3 && cyc == 20) begin
        start = 1'b1; num_gates = 5'd1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 18'h3ffff;
      end else if (mode == 3 && cyc == 21) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (prev_stall) chk("stall_valid", 128'(tt_valid), 128'd1);
      prev_stall = 1'b0;
      if (tt_valid) begin
        chk("idx", 128'(tt_index), 128'(idx));
        chk("bit", 128'(tt_bit), 128'(exp[idx[6:0]]));
        case (mode)
          1:       tt_ready = 1'($urandom_range(0, 1));
          2:       tt_ready = !(idx == 10 && stall < 5);
          default: tt_ready = 1'b1;
        endcase
        if (mode == 2 && idx == 10 && stall < 5) stall++;
        if (tt_ready) begin
          c[idx[6:0]] = tt_bit;
          idx++;
        end else prev_stall = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 6000) chk("timeout", 128'd0, 128'd1);
    chk("count", 128'(idx), 128'd128);
    if (mode == 0 || mode == 3) chk("latency", 128'(cyc - 1), 128'(128 * (n + 1)));
    chk("done_busy", 128'(busy), 128'd1);
    @(negedge clk);
    chk("done_pulse", 128'({done, busy}), 128'd0);
`ifdef TT_CAPTURE_EN
    chk("word", tt_word, exp);
`else
    chk("word0", tt_word, 128'd0);
`endif
  endtask

  task automatic bad_start(input logic [4:0] n);
    @(negedge clk);
    start = 1'b1; num_gates = n;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 128'({err, busy}), 128'd2);
    @(negedge clk);
    chk("err_clear", 128'({err, busy}), 128'd0);
  endtask

  initial begin
    logic [127:0] k8, k7;
    int wait_cyc;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    k8 = {32{4'h8}};
    k7 = {32{4'h7}};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", 128'({busy, done, err, tt_valid, tt_bit, tt_index}), 128'd0);
    chk("reset_word", tt_word, 128'd0);

    wr(4'd0, 18'h01083);
    sweep(1, 1'b0, 0, 1'b0, 4'd0, 18'd0, col);
    chk("maj_idx3", 128'(col[3]), 128'd1);
    chk("maj_idx4", 128'(col[4]), 128'd0);
    chk("maj_idx7", 128'(col[7]), 128'd1);

    sweep(1, 1'b0, 0, 1'b1, 4'd0, 18'h01080, col);
    chk("and_tt", col, k8);
    sweep(1, 1'b1, 0, 1'b0, 4'd0, 18'd0, col);
    chk("and_inv_tt", col, k7);

    wr(4'd0, 18'h010C5);
    wr(4'd1, 18'h02108);
    sweep(2, 1'b0, 0, 1'b0, 4'd0, 18'd0, col);
    chk("chain_0b", 128'(col[11]), 128'd1);
    chk("chain_05", 128'(col[5]), 128'd0);
    sweep(2, 1'b0, 2, 1'b0, 4'd0, 18'd0, col);
    sweep(2, 1'b0, 3, 1'b0, 4'd0, 18'd0, col);

    bad_start(5'd0);
    bad_start(5'd17);

    for (int t = 0; t < 4; t++) begin
      for (int g = 0; g < 16; g++)
        wr(4'(g), {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))});
      sweep($urandom_range(1, 16), 1'($urandom_range(0, 1)), 1, 1'b0, 4'd0, 18'd0, col);
    end

    // Abort a sweep with reset when minterm 50 is on the stream.
    @(negedge clk);
    start = 1'b1; num_gates = 5'd16; out_inv = 1'b0; tt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!(tt_valid && tt_index == 7'd50) && wait_cyc < 3000) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 3000) chk("rst_wait_timeout", 128'd0, 128'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 128'({busy, done, err, tt_valid, tt_bit, tt_index}), 128'd0);
    chk("rst_word", tt_word, 128'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 128'({busy, done}), 128'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    sweep(1, 1'b0, 0, 1'b0, 4'd0, 18'd0, col);
    chk("rst_tab_clear", col, 128'd0);
    wr(4'd0, 18'h01083);
    sweep(1, 1'b0, 1, 1'b0, 4'd0, 18'd0, col);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
